gps_fix_flash_ctrl: RTL and testbench
=====================================

// Module: gps_fix_flash_ctrl
// PURPOSE
//  Producer of the flash-control pair consumed by the 7-seg flash masker.
//  Samples the raw PmodGPS 3DF pin, synchronises and deglitches it, and classifies it:
//  - toggling pin => no fix => state_o=1 (flash), threedf_o = clean pin phase.
//  - steady pin => state_o=0 (segments pass through unchanged).
// PARAMETERS
//  CLK_HZ        12_000_000  system clock frequency; ms tick = CLK_HZ/1000 cycles
//  SYNC_STAGES   2           metastability flops on threedf_pin_i (>=2)
//  GLITCH_CYC    1200        consecutive cycles a new level must persist before acceptance
//  TIMEOUT_MS    1500        ms without a filtered edge before returning to STEADY
//  CONFIRM_EDGES 2           filtered edges needed in ACQ before entering FLASH (>=1)
// PORTS
//  clk_i          input   1  system clock; single clock domain
//  reset_i        input   1  synchronous, active-high reset
//  threedf_pin_i  input   1  raw asynchronous 3DF pin from PmodGPS
//  enable_i       input   1  0 forces STEADY and clears all counters; 1 runs the classifier
//  state_o        output  1  flash request to masker; 1 in FLASH only
//  threedf_o      output  1  flash phase: filtered level in FLASH, else 1 (bright)
//  edge_o         output  1  1-cycle pulse on each accepted filtered edge
// BEHAVIOUR
//  Reset (reset_i=1 at a clk_i edge; dominates enable_i and all inputs):
//   sync chain=0, filt=0, all counters=0, FSM=STEADY, state_o=0, threedf_o=1, edge_o=0.
//  Sync: pin passes through SYNC_STAGES flops -> s.
//  Deglitch:
//   - gcnt clears while s==filt; increments while s!=filt.
//   - When s!=filt and gcnt==GLITCH_CYC-1, filt<=s and gcnt<=0. Shorter pulses never reach filt.
//   - Pin change to filt change = SYNC_STAGES+GLITCH_CYC cycles.
//  Edge: edge_o=1 in the first cycle filt holds its new value (filt != filt_q).
//  Timeout:
//   - Prescaler counts 0..CLK_HZ/1000-1 and issues a 1-cycle ms tick on wrap.
//   - mscnt counts ticks and saturates at TIMEOUT_MS. timeout = (mscnt==TIMEOUT_MS).
//   - edge_o clears the prescaler and mscnt in the same cycle.
//  FSM (registered; outputs are decoded from registered state):
//   STEADY: edge -> ACQ, ecnt=1; ACQ immediately if CONFIRM_EDGES==1 -> FLASH.
//   ACQ: edge -> ecnt+1; at ecnt+1==CONFIRM_EDGES -> FLASH; timeout -> STEADY, ecnt=0.
//   FLASH: timeout -> STEADY; edges keep FLASH.
//   Edge and timeout in the same cycle: edge wins (counter clear has priority).
//   enable_i=0: next state STEADY; ecnt, mscnt and prescaler cleared.
//     Sync and deglitch keep running, but edge_o is masked to 0.
//  Output timing: state_o changes 1 cycle after the edge_o/timeout cycle that caused it.
//   threedf_o = FLASH ? filt : 1.
//  Widths: gcnt $clog2(GLITCH_CYC+1); prescaler $clog2(CLK_HZ/1000);
//   mscnt $clog2(TIMEOUT_MS+1); ecnt $clog2(CONFIRM_EDGES+1). No wrap anywhere; all counters saturate or clear.
//  Reset mid-operation (any state): same as power-on; a new fix sequence requires fresh edges.
// STRUCTURE
//  Shared package ssd_pkg:
//   typedef enum logic [1:0] {FIX_STEADY, FIX_ACQ, FIX_FLASH} fix_state_e;
//   localparam SSD_BLANK = 7'b1111111 (active-low all-off).
//  One sub-module, sync_deglitch (params SYNC_STAGES, GLITCH_CYC; ports clk_i, reset_i, d_i, q_o, edge_o).
//   It is reused for future Pmod button inputs.
//  Top level holds the prescaler, mscnt, ecnt and FSM.
// TESTING (bench params: CLK_HZ=10_000 [10 cyc/ms], GLITCH_CYC=4, TIMEOUT_MS=5, CONFIRM_EDGES=2, SYNC_STAGES=2)
//  1. Reset: toggle pin every cycle with reset_i=1 for 5 cycles -> state_o=0, threedf_o=1, edge_o=0 throughout.
//  2. Glitch: pin 0->1 for 3 cycles then 0 -> no edge_o, filt stays 0.
//     Pin 0->1 held -> edge_o exactly 6 cycles after the rise.
//  3. Acquire: pin toggles every 20 cycles -> 1st edge_o: ACQ, state_o=0.
//     2nd edge_o: state_o=1 next cycle, threedf_o tracks filt.
//  4. Timeout: in FLASH hold pin steady -> state_o=0 on cycle 51 after last edge_o, threedf_o=1.
//     In ACQ, same timing back to STEADY.
//  5. Coincidence: in FLASH, edge_o lands on the same cycle as timeout (cycle 50) -> state_o stays 1, mscnt=0.
//  6. Enable/reset mid-op: enable_i=0 in FLASH -> state_o=0 next cycle.
//     Re-enable -> needs 2 new edges before state_o=1. reset_i pulse in ACQ -> STEADY, ecnt=0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display and GPS fix flash path.
package ssd_pkg;

    typedef enum logic [1:0] {
        FIX_STEADY = 2'd0,
        FIX_ACQ    = 2'd1,
        FIX_FLASH  = 2'd2
    } fix_state_e;

    // Active-low segment pattern with every segment off.
    localparam logic [6:0] SSD_BLANK = 7'b1111111;

endpackage

// File: rtl/sync_deglitch.sv
// Synchroniser plus persistence filter for a slow asynchronous level input.
// A new level must be seen for GLITCH_CYC consecutive synchronised cycles before it is accepted.
module sync_deglitch #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GLITCH_CYC  = 1200
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o,
    output logic edge_o
);

    localparam int unsigned GW = $clog2(GLITCH_CYC + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [GW-1:0]          gcnt;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Metastability chain; the last stage is the usable synchronised level.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    // Persistence counter; edge_o is high in the first cycle q_o shows its new level.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gcnt   <= '0;
            q_o    <= 1'b0;
            edge_o <= 1'b0;
        end else begin
            edge_o <= 1'b0;
            if (s == q_o) begin
                gcnt <= '0;
            end else if (gcnt == GW'(GLITCH_CYC - 1)) begin
                q_o    <= s;
                gcnt   <= '0;
                edge_o <= 1'b1;
            end else begin
                gcnt <= gcnt + GW'(1);
            end
        end
    end

endmodule

// File: rtl/gps_fix_flash_ctrl.sv
// Classifies the PmodGPS 3DF pin: a toggling pin (no fix) requests segment flashing,
// a steady pin lets the segments pass through.
module gps_fix_flash_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 12_000_000,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned GLITCH_CYC    = 1200,
    parameter int unsigned TIMEOUT_MS    = 1500,
    parameter int unsigned CONFIRM_EDGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic threedf_pin_i,
    input  logic enable_i,
    output logic state_o,
    output logic threedf_o,
    output logic edge_o
);

    localparam int unsigned MS_CYC = CLK_HZ / 1000;
    localparam int unsigned PW     = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int unsigned MW     = $clog2(TIMEOUT_MS + 1);
    localparam int unsigned EW     = $clog2(CONFIRM_EDGES + 1);

    // The edge cycle itself is the first cycle of the new millisecond.
    localparam logic [PW-1:0] PRESC_RESTART = (MS_CYC > 1) ? PW'(1) : '0;

    fix_state_e    state;
    logic          filt;
    logic          raw_edge;
    logic [PW-1:0] presc;
    logic [MW-1:0] mscnt;
    logic [EW-1:0] ecnt;
    logic          ms_tick;
    logic          timeout;

    sync_deglitch #(
        .SYNC_STAGES (SYNC_STAGES),
        .GLITCH_CYC  (GLITCH_CYC)
    ) u_sd (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (threedf_pin_i),
        .q_o     (filt),
        .edge_o  (raw_edge)
    );

    assign edge_o    = raw_edge & enable_i;
    assign ms_tick   = (presc == PW'(MS_CYC - 1));
    assign timeout   = (mscnt == MW'(TIMEOUT_MS));
    assign threedf_o = state_o ? filt : 1'b1;

    // Millisecond prescaler and saturating silence timer, restarted by every accepted edge.
    always_ff @(posedge clk_i) begin
        if (reset_i || !enable_i) begin
            presc <= '0;
            mscnt <= '0;
        end else if (edge_o) begin
            presc <= PRESC_RESTART;
            mscnt <= '0;
        end else if (ms_tick) begin
            presc <= '0;
            if (!timeout) begin
                mscnt <= mscnt + MW'(1);
            end
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Fix classifier; an edge beats a coincident timeout.
    always_ff @(posedge clk_i) begin
        if (reset_i || !enable_i) begin
            state   <= FIX_STEADY;
            ecnt    <= '0;
            state_o <= 1'b0;
        end else begin
            case (state)
                FIX_STEADY: begin
                    if (edge_o) begin
                        if (CONFIRM_EDGES == 1) begin
                            state   <= FIX_FLASH;
                            ecnt    <= '0;
                            state_o <= 1'b1;
                        end else begin
                            state <= FIX_ACQ;
                            ecnt  <= EW'(1);
                        end
                    end
                end
                FIX_ACQ: begin
                    if (edge_o) begin
                        if ((ecnt + EW'(1)) == EW'(CONFIRM_EDGES)) begin
                            state   <= FIX_FLASH;
                            ecnt    <= '0;
                            state_o <= 1'b1;
                        end else begin
                            ecnt <= ecnt + EW'(1);
                        end
                    end else if (timeout) begin
                        state <= FIX_STEADY;
                        ecnt  <= '0;
                    end
                end
                FIX_FLASH: begin
                    if (!edge_o && timeout) begin
                        state   <= FIX_STEADY;
                        state_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= FIX_STEADY;
                    ecnt    <= '0;
                    state_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gps_fix_flash_ctrl.sv
// Directed bench for gps_fix_flash_ctrl with an edge scoreboard.
module tb_gps_fix_flash_ctrl;
    import ssd_pkg::*;

    typedef struct {
        int   cyc;
        logic lvl;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic pin;
    logic en;
    logic state_o;
    logic threedf_o;
    logic edge_o;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  sb[$];

    gps_fix_flash_ctrl #(
        .CLK_HZ        (10_000),
        .SYNC_STAGES   (2),
        .GLITCH_CYC    (4),
        .TIMEOUT_MS    (5),
        .CONFIRM_EDGES (2)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .threedf_pin_i (pin),
        .enable_i      (en),
        .state_o       (state_o),
        .threedf_o     (threedf_o),
        .edge_o        (edge_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    // One clock; edge_o is compared every cycle against the scoreboard head.
    task automatic tick();
        logic exp_e;
        ev_t  ev;
        @(posedge clk);
        #1;
        cyc++;
        exp_e = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("edge_o", 32'(edge_o), 32'(exp_e));
        if (exp_e) begin
            ev = sb.pop_front();
            chk("filt_at_edge", 32'(dut.filt), 32'(ev.lvl));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // A held pin change shows up on edge_o SYNC_STAGES+GLITCH_CYC = 6 cycles later.
    task automatic drive(input logic v, input bit accept);
        pin = v;
        if (accept) sb.push_back('{cyc + 6, v});
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        pin = 1'b0;

        // Reset dominates a toggling pin.
        for (int i = 0; i < 5; i++) begin
            pin = ~pin;
            tick();
            chk("rst_state_o", 32'(state_o), 32'd0);
            chk("rst_threedf_o", 32'(threedf_o), 32'd1);
        end
        pin = 1'b0;
        rst = 1'b0;
        run(10);

        // 3-cycle glitch is rejected.
        drive(1'b1, 1'b0);
        run(3);
        drive(1'b0, 1'b0);
        run(12);
        chk("glitch_filt", 32'(dut.filt), 32'd0);
        chk("glitch_state", 32'(dut.state), 32'(FIX_STEADY));

        // Held rise: first edge, enter ACQ.
        drive(1'b1, 1'b1);
        run(6);
        chk("e1_state_o", 32'(state_o), 32'd0);
        run(1);
        chk("acq_state_o", 32'(state_o), 32'd0);
        chk("acq_state", 32'(dut.state), 32'(FIX_ACQ));
        chk("acq_ecnt", 32'(dut.ecnt), 32'd1);

        // Second edge 20 cycles later: FLASH one cycle after it.
        run(13);
        drive(1'b0, 1'b1);
        run(6);
        chk("e2_state_o", 32'(state_o), 32'd0);
        run(1);
        chk("flash_state_o", 32'(state_o), 32'd1);
        chk("flash_thr_lo", 32'(threedf_o), 32'd0);

        // threedf_o follows the filtered level while flashing.
        run(13);
        drive(1'b1, 1'b1);
        run(5);
        chk("track_before", 32'(threedf_o), 32'd0);
        run(1);
        chk("track_hi", 32'(threedf_o), 32'd1);
        run(14);
        drive(1'b0, 1'b1);
        run(6);
        chk("track_lo", 32'(threedf_o), 32'd0);

        // Edge on the same cycle as timeout (50 cycles after the last edge) keeps FLASH.
        run(44);
        drive(1'b1, 1'b1);
        run(6);
        chk("coin_mscnt_sat", 32'(dut.mscnt), 32'd5);
        chk("coin_state_o", 32'(state_o), 32'd1);
        run(1);
        chk("coin_after_state_o", 32'(state_o), 32'd1);
        chk("coin_mscnt_clr", 32'(dut.mscnt), 32'd0);

        // Steady pin in FLASH: state_o drops on cycle 51 after the last edge.
        run(49);
        chk("to_flash_hold", 32'(state_o), 32'd1);
        run(1);
        chk("to_flash_state_o", 32'(state_o), 32'd0);
        chk("to_flash_thr", 32'(threedf_o), 32'd1);
        chk("to_flash_state", 32'(dut.state), 32'(FIX_STEADY));

        // Single edge then silence: ACQ times out with the same timing.
        drive(1'b0, 1'b1);
        run(7);
        chk("to_acq_enter", 32'(dut.state), 32'(FIX_ACQ));
        run(49);
        chk("to_acq_hold", 32'(dut.state), 32'(FIX_ACQ));
        run(1);
        chk("to_acq_state", 32'(dut.state), 32'(FIX_STEADY));
        chk("to_acq_ecnt", 32'(dut.ecnt), 32'd0);

        // Back to FLASH, then disable.
        drive(1'b1, 1'b1);
        run(7);
        run(13);
        drive(1'b0, 1'b1);
        run(7);
        chk("re_flash", 32'(state_o), 32'd1);
        en = 1'b0;
        run(1);
        chk("dis_state_o", 32'(state_o), 32'd0);
        chk("dis_thr", 32'(threedf_o), 32'd1);
        drive(1'b1, 1'b0);
        run(10);
        chk("dis_filt_runs", 32'(dut.filt), 32'd1);
        chk("dis_state", 32'(dut.state), 32'(FIX_STEADY));
        en = 1'b1;
        run(3);

        // Re-enabled: two fresh edges needed.
        drive(1'b0, 1'b1);
        run(7);
        chk("reen_e1_state_o", 32'(state_o), 32'd0);
        chk("reen_e1_state", 32'(dut.state), 32'(FIX_ACQ));
        run(13);
        drive(1'b1, 1'b1);
        run(7);
        chk("reen_e2_state_o", 32'(state_o), 32'd1);

        // Reset pulse in ACQ.
        en = 1'b0;
        run(1);
        en = 1'b1;
        run(1);
        chk("pre_rst_steady", 32'(dut.state), 32'(FIX_STEADY));
        drive(1'b0, 1'b1);
        run(7);
        chk("pre_rst_acq", 32'(dut.state), 32'(FIX_ACQ));
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        chk("rst_acq_state", 32'(dut.state), 32'(FIX_STEADY));
        chk("rst_acq_ecnt", 32'(dut.ecnt), 32'd0);
        chk("rst_acq_state_o", 32'(state_o), 32'd0);
        run(10);
        drive(1'b1, 1'b1);
        run(7);
        chk("post_rst_state", 32'(dut.state), 32'(FIX_ACQ));
        chk("post_rst_state_o", 32'(state_o), 32'd0);
        run(10);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
